scanline_raster_engine: RTL and testbench

- Parametrised successor of the row-buffer rasteriser: renders a frame one scanline at a time.
- Per row: the row buffer is cleared to clear_color, every primitive is fetched from geometry memory and painted in painter's order, then the row is written to the framebuffer port as packed words.
- Adds start/busy/done frame handshake, configurable read latency, write backpressure and per-row clearing.
- Sits between geometry memory and the framebuffer BRAM write port A.

---
 rtl/raster_pkg.sv | 43 ++++
 rtl/rect_coverage.sv | 25 ++
 rtl/scanline_raster_engine.sv | 175 +++++++++++++++++
 tb/tb_scanline_raster_engine.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types for the scanline rasteriser: primitive record layout and FSM states.
package raster_pkg;

    localparam int REC_W       = 256;
    localparam int REC_COORD_W = 9;
    localparam int REC_COLOR_W = 16;
    localparam int X0_LSB      = 0;
    localparam int Y0_LSB      = 16;
    localparam int X1_LSB      = 32;
    localparam int Y1_LSB      = 48;
    localparam int COLOR_LSB   = 128;

    typedef struct packed {
        logic [REC_COORD_W-1:0] x0;
        logic [REC_COORD_W-1:0] y0;
        logic [REC_COORD_W-1:0] x1;
        logic [REC_COORD_W-1:0] y1;
    } rect_t;

    typedef struct packed {
        rect_t                  rect;
        logic [REC_COLOR_W-1:0] color;
    } prim_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_DRAIN,
        ST_DUMP
    } state_t;

    function automatic prim_t unpack_prim(input logic [REC_W-1:0] rec);
        prim_t p;
        p.rect.x0 = rec[X0_LSB +: REC_COORD_W];
        p.rect.y0 = rec[Y0_LSB +: REC_COORD_W];
        p.rect.x1 = rec[X1_LSB +: REC_COORD_W];
        p.rect.y1 = rec[Y1_LSB +: REC_COORD_W];
        p.color   = rec[COLOR_LSB +: REC_COLOR_W];
        return p;
    endfunction

endpackage

// File: rtl/rect_coverage.sv
// Per-pixel coverage of one inclusive rectangle on the current row.
// Inverted bounds fall out naturally as an empty mask.
module rect_coverage
    import raster_pkg::*;
#(
    parameter int ROW_W   = 320,
    parameter int COORD_W = 9
) (
    input  rect_t              rect,
    input  logic [COORD_W-1:0] row,
    output logic [ROW_W-1:0]   covered
);

    logic row_hit;

    assign row_hit = (int'(rect.y0) <= int'(row)) && (int'(row) <= int'(rect.y1));

    always_comb begin
        covered = '0;
        for (int x = 0; x < ROW_W; x++) begin
            covered[x] = row_hit && (int'(rect.x0) <= x) && (x <= int'(rect.x1));
        end
    end

endmodule

// File: rtl/scanline_raster_engine.sv
// Renders a frame one row at a time: clear, paint every primitive in order, stream the row out.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for start
//   ST_CLEAR | row buffer <= clear colour, primitive index rewound
//   ST_FETCH | one geometry read issued per cycle
//   ST_DRAIN | last GMEM_LAT returns still in flight
//   ST_DUMP  | packed words offered to the framebuffer
module scanline_raster_engine
    import raster_pkg::*;
#(
    parameter int ROW_W        = 320,
    parameter int ROWS         = 240,
    parameter int COORD_W      = 9,
    parameter int PIX_W        = 16,
    parameter int PIX_PER_WORD = 2,
    parameter int GMEM_LAT     = 1,
    parameter int FB_AW        = 17
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          start,
    input  logic [15:0]                   prim_count,
    input  logic [PIX_W-1:0]              clear_color,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   gmem_addr,
    input  logic [255:0]                  gmem_dout,
    output logic                          fb_wvalid,
    input  logic                          fb_wready,
    output logic [FB_AW-1:0]              fb_waddr,
    output logic [PIX_W*PIX_PER_WORD-1:0] fb_wdata
);

    localparam int WPR       = ROW_W / PIX_PER_WORD;
    localparam int ROW_BITS  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WORD_BITS = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int LAT_BITS  = (GMEM_LAT > 1) ? $clog2(GMEM_LAT) : 1;
    localparam int IDX_W     = (ROW_W > 1) ? $clog2(ROW_W) : 1;

    localparam logic [ROW_BITS-1:0]  LAST_ROW  = ROW_BITS'(ROWS - 1);
    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WPR - 1);

    state_t               state;
    logic [15:0]          prim_cnt_q;
    logic [15:0]          index_q;
    logic [PIX_W-1:0]     clear_q;
    logic [ROW_BITS-1:0]  row_q;
    logic [WORD_BITS-1:0] word_q;
    logic [LAT_BITS-1:0]  drain_cnt;
    logic [GMEM_LAT-1:0]  vpipe;
    logic [PIX_W-1:0]     row_buf [ROW_W];
    prim_t                rec;
    logic [COORD_W-1:0]   row_coord;
    logic [ROW_W-1:0]     covered;
    logic                 accept;
    logic [IDX_W-1:0]     pix_idx;

    assign rec       = unpack_prim(gmem_dout);
    assign row_coord = COORD_W'(row_q);
    assign accept    = fb_wvalid && fb_wready;
    assign gmem_addr = index_q;
    assign fb_waddr  = FB_AW'(row_q) * FB_AW'(WPR) + FB_AW'(word_q);

    rect_coverage #(
        .ROW_W   (ROW_W),
        .COORD_W (COORD_W)
    ) u_cov (
        .rect    (rec.rect),
        .row     (row_coord),
        .covered (covered)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            fb_wvalid  <= 1'b0;
            prim_cnt_q <= '0;
            clear_q    <= '0;
            index_q    <= '0;
            row_q      <= '0;
            word_q     <= '0;
            drain_cnt  <= '0;
            vpipe      <= '0;
        end else begin
            done  <= 1'b0;
            // Bit GMEM_LAT-1 marks the cycle a fetched record is on gmem_dout.
            vpipe <= GMEM_LAT'({vpipe, state == ST_FETCH});
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        prim_cnt_q <= prim_count;
                        clear_q    <= clear_color;
                        row_q      <= '0;
                        busy       <= 1'b1;
                        state      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    index_q <= '0;
                    word_q  <= '0;
                    if (prim_cnt_q != 16'd0) begin
                        state <= ST_FETCH;
                    end else begin
                        fb_wvalid <= 1'b1;
                        state     <= ST_DUMP;
                    end
                end
                ST_FETCH: begin
                    if (index_q == prim_cnt_q - 16'd1) begin
                        drain_cnt <= LAT_BITS'(GMEM_LAT - 1);
                        state     <= ST_DRAIN;
                    end else begin
                        index_q <= index_q + 16'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        fb_wvalid <= 1'b1;
                        state     <= ST_DUMP;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (accept) begin
                        if (word_q == LAST_WORD) begin
                            fb_wvalid <= 1'b0;
                            word_q    <= '0;
                            if (row_q == LAST_ROW) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= ST_IDLE;
                            end else begin
                                row_q <= row_q + 1'b1;
                                state <= ST_CLEAR;
                            end
                        end else begin
                            word_q <= word_q + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Contents are meaningless after reset, so the buffer carries no reset.
    always_ff @(posedge Clk) begin
        if (state == ST_CLEAR) begin
            for (int x = 0; x < ROW_W; x++) begin
                row_buf[x] <= clear_q;
            end
        end else if (vpipe[GMEM_LAT-1]) begin
            for (int x = 0; x < ROW_W; x++) begin
                if (covered[x]) begin
                    row_buf[x] <= PIX_W'(rec.color);
                end
            end
        end
    end

    always_comb begin
        fb_wdata = '0;
        pix_idx  = '0;
        for (int p = 0; p < PIX_PER_WORD; p++) begin
            pix_idx = IDX_W'(int'(word_q) * PIX_PER_WORD + p);
            fb_wdata[(PIX_PER_WORD-1-p)*PIX_W +: PIX_W] = row_buf[pix_idx];
        end
    end

endmodule

// File: tb/tb_scanline_raster_engine.sv
// Bench for scanline_raster_engine on a tiny 8x2 frame with a 3-cycle geometry memory.
module tb_scanline_raster_engine;
    import raster_pkg::*;

    localparam int ROW_W = 8;
    localparam int ROWS  = 2;
    localparam int PPW   = 2;
    localparam int LAT   = 3;
    localparam int FB_AW = 8;
    localparam int WPR   = ROW_W / PPW;
    localparam int NW    = WPR * ROWS;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          start;
    logic [15:0]   prim_count;
    logic [15:0]   clear_color;
    logic          busy;
    logic          done;
    logic [15:0]   gmem_addr;
    logic [255:0]  gmem_dout;
    logic          fb_wvalid;
    logic          fb_wready;
    logic [FB_AW-1:0] fb_waddr;
    logic [31:0]   fb_wdata;

    always #5 Clk = ~Clk;

    scanline_raster_engine #(
        .ROW_W(ROW_W), .ROWS(ROWS), .COORD_W(9), .PIX_W(16),
        .PIX_PER_WORD(PPW), .GMEM_LAT(LAT), .FB_AW(FB_AW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .prim_count(prim_count),
        .clear_color(clear_color), .busy(busy), .done(done), .gmem_addr(gmem_addr),
        .gmem_dout(gmem_dout), .fb_wvalid(fb_wvalid), .fb_wready(fb_wready),
        .fb_waddr(fb_waddr), .fb_wdata(fb_wdata)
    );

    // Geometry memory with LAT cycles of read latency.
    logic [255:0] mem [16];
    logic [255:0] gp1, gp2;
    always @(posedge Clk) begin
        gp1       <= mem[gmem_addr[3:0]];
        gp2       <= gp1;
        gmem_dout <= gp2;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t cap[$];

    typedef struct {
        int                   n;
        logic [15:0]          clr;
        logic [0:3][255:0]    recs;
        logic [0:NW-1][31:0]  exp;
        int                   mode;
    } vec_t;
    vec_t vt[4];

    typedef struct {
        int x0, y0, x1, y1;
        logic [15:0] color;
    } tprim_t;
    tprim_t rp[16];
    logic [0:NW-1][31:0] exp_m;

    function automatic logic [255:0] mk_rec(input int x0, input int y0, input int x1,
                                            input int y1, input logic [15:0] c);
        logic [255:0] r;
        r = '0;
        r[8:0]     = 9'(x0);
        r[24:16]   = 9'(y0);
        r[40:32]   = 9'(x1);
        r[56:48]   = 9'(y1);
        r[143:128] = c;
        return r;
    endfunction

    // Painter's-order reference: last covering primitive wins, else background.
    task automatic model_frame(input int n, input logic [15:0] clr);
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < WPR; w++) begin
                logic [31:0] word;
                for (int k = 0; k < PPW; k++) begin
                    int x;
                    logic [15:0] c;
                    x = w * PPW + k;
                    c = clr;
                    for (int i = 0; i < n; i++) begin
                        if (rp[i].x0 <= x && x <= rp[i].x1 && rp[i].y0 <= r && r <= rp[i].y1)
                            c = rp[i].color;
                    end
                    if (k == 0) word[31:16] = c;
                    else        word[15:0]  = c;
                end
                exp_m[r*WPR + w] = word;
            end
        end
    endtask

    // Monitor, sampled at the falling edge.
    int  cyc = 0;
    int  done_cnt = 0;
    int  cur_n = 0;
    int  clr_t = 0;
    bit  prev_busy = 0, prev_wv = 0, prev_stall = 0;
    logic [FB_AW-1:0] p_addr;
    logic [31:0] p_data;

    initial forever begin
        @(negedge Clk);
        cyc++;
        if (Reset) begin
            prev_busy  = 0;
            prev_wv    = 0;
            prev_stall = 0;
            continue;
        end
        if (busy && !prev_busy) clr_t = cyc;
        if (fb_wvalid && !prev_wv)
            check("dump_latency", 64'(cyc - clr_t), 64'(1 + cur_n + ((cur_n != 0) ? LAT : 0)));
        if (prev_stall) begin
            check("stall_valid", fb_wvalid, 1);
            check("stall_addr", fb_waddr, p_addr);
            check("stall_data", fb_wdata, p_data);
        end
        if (fb_wvalid && fb_wready) begin
            cap.push_back('{a: fb_waddr, d: fb_wdata});
            if (fb_waddr[1:0] == 2'd3) clr_t = cyc + 1;
        end
        if (done) begin
            done_cnt++;
            check("busy_with_done", busy, 0);
        end
        prev_stall = fb_wvalid && !fb_wready;
        p_addr     = fb_waddr;
        p_data     = fb_wdata;
        prev_busy  = busy;
        prev_wv    = fb_wvalid;
    end

    // Ready generator: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    int rdy_mode = 0;
    int pk = 0;
    logic [3:0] pat = 4'b1001;
    initial begin
        fb_wready = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            case (rdy_mode)
                1: begin
                    if (fb_wvalid) begin
                        fb_wready = pat[3 - (pk % 4)];
                        pk++;
                    end else begin
                        fb_wready = 1'b0;
                    end
                end
                2: fb_wready = 1'($urandom_range(0, 1));
                default: fb_wready = 1'b1;
            endcase
        end
    end

    task automatic run_frame(input string tag, input int n, input logic [15:0] clr,
                             input logic [0:NW-1][31:0] exp, input int mode, input bit poke);
        cap.delete();
        done_cnt = 0;
        cur_n    = n;
        rdy_mode = mode;
        pk       = 0;
        @(posedge Clk); #1;
        prim_count  = 16'(n);
        clear_color = clr;
        start       = 1'b1;
        @(posedge Clk); #1;
        start       = 1'b0;
        prim_count  = 16'(n + 5);
        clear_color = ~clr;
        if (poke) begin
            for (int k = 0; k < 200; k++) begin
                if (fb_wvalid) break;
                @(posedge Clk); #1;
            end
            start       = 1'b1;
            prim_count  = 16'd0;
            clear_color = 16'h1234;
            @(posedge Clk); #1;
            start       = 1'b0;
        end
        for (int k = 0; k < 3000; k++) begin
            @(negedge Clk);
            if (done_cnt != 0) break;
        end
        repeat (5) @(negedge Clk);
        check($sformatf("%s_done_count", tag), 64'(done_cnt), 1);
        check($sformatf("%s_busy_idle", tag), busy, 0);
        check($sformatf("%s_wr_count", tag), 64'(cap.size()), 64'(NW));
        for (int i = 0; i < NW; i++) begin
            if (i < cap.size()) begin
                check($sformatf("%s_addr%0d", tag, i), cap[i].a, 64'(i));
                check($sformatf("%s_data%0d", tag, i), cap[i].d, exp[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        start = 1'b0;
        prim_count = '0;
        clear_color = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        vt[0].n = 0; vt[0].clr = 16'hF800; vt[0].mode = 0; vt[0].recs = '0;
        vt[0].exp = {NW{32'hF800F800}};

        vt[1].n = 1; vt[1].clr = 16'h0000; vt[1].mode = 0; vt[1].recs = '0;
        vt[1].recs[0] = mk_rec(2, 0, 5, 0, 16'h07E0);
        vt[1].exp = {32'h00000000, 32'h07E007E0, 32'h07E007E0, 32'h00000000,
                     32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

        vt[2].n = 2; vt[2].clr = 16'h0000; vt[2].mode = 1; vt[2].recs = '0;
        vt[2].recs[0] = mk_rec(0, 0, 7, 1, 16'h001F);
        vt[2].recs[1] = mk_rec(3, 0, 4, 1, 16'hFFFF);
        vt[2].exp = {32'h001F001F, 32'h001FFFFF, 32'hFFFF001F, 32'h001F001F,
                     32'h001F001F, 32'h001FFFFF, 32'hFFFF001F, 32'h001F001F};

        vt[3].n = 4; vt[3].clr = 16'hAAAA; vt[3].mode = 0;
        vt[3].recs[0] = mk_rec(0, 0, 7, 1, 16'h1111);
        vt[3].recs[1] = mk_rec(0, 1, 3, 1, 16'h2222);
        vt[3].recs[2] = mk_rec(5, 0, 2, 1, 16'h3333);
        vt[3].recs[3] = mk_rec(6, 0, 20, 9, 16'h4444);
        vt[3].exp = {32'h11111111, 32'h11111111, 32'h11111111, 32'h44444444,
                     32'h22222222, 32'h22222222, 32'h11111111, 32'h44444444};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wvalid", fb_wvalid, 0);
        check("rst_gmem_addr", gmem_addr, 0);
        check("rst_waddr", fb_waddr, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 4; i++) mem[i] = vt[t].recs[i];
            run_frame($sformatf("vec%0d", t), vt[t].n, vt[t].clr, vt[t].exp, vt[t].mode, 1'b0);
        end

        // Abort mid-dump, then a clean frame with a stray start while busy.
        for (int i = 0; i < 4; i++) mem[i] = vt[1].recs[i];
        cap.delete();
        cur_n = 1;
        rdy_mode = 0;
        @(posedge Clk); #1;
        prim_count = 16'd1; clear_color = 16'h0000; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (cap.size() >= 2) break;
            @(posedge Clk); #1;
        end
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("abort_wvalid", fb_wvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_waddr", fb_waddr, 0);
        check("abort_gmem_addr", gmem_addr, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        run_frame("after_abort", vt[1].n, vt[1].clr, vt[1].exp, 0, 1'b1);

        for (int r = 0; r < 20; r++) begin
            int n;
            logic [15:0] clr;
            n   = $urandom_range(0, 8);
            clr = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                rp[i].x0 = $urandom_range(0, 9);
                rp[i].x1 = $urandom_range(0, 11);
                rp[i].y0 = $urandom_range(0, 2);
                rp[i].y1 = $urandom_range(0, 2);
                rp[i].color = 16'($urandom);
                mem[i] = mk_rec(rp[i].x0, rp[i].y0, rp[i].x1, rp[i].y1, rp[i].color);
            end
            model_frame(n, clr);
            run_frame($sformatf("rand%0d", r), n, clr, exp_m, 2, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
